nvram_upload_ctrl: RTL

NVRAM_UPLOAD_CTRL -- requirements
Module: nvram_upload_ctrl

---
 rtl/bubsys_pkg.sv | 27 ++
 rtl/nvram_upload_ctrl_if.sv | 46 ++++
 rtl/nvram_quiet_timer.sv | 40 ++++
 rtl/nvram_upload_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bubsys_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bubsys_pkg
//  Description : Shared types and constants for the save-RAM upload path.
//                Holds the upload FSM state encoding and the ioctl index
//                that identifies the NVRAM save slot on the HPS side.
//  Revision    : 1.0 - initial release
// ============================================================================
package bubsys_pkg;

    // Upload read FSM: wait for a request, issue the RAM read, let the
    // RAM pipeline drain, then hold the byte for one cycle with wait low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAT   = 2'd2,
        HOLD  = 2'd3
    } nvram_state_t;

    // ioctl index the HPS uses for the save-RAM image
    localparam logic [15:0] c_NVRAM_INDEX = 16'd4;

    // Value returned for addresses beyond the save image and after reset
    localparam logic [7:0]  c_BLANK_BYTE  = 8'hFF;

endpackage : bubsys_pkg
`default_nettype wire

// File: rtl/nvram_upload_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_upload_ctrl_if
//  Description : HPS ioctl upload bus between the HPS bridge (master) and
//                the save-RAM upload controller (slave).
//  Signals     : ioctl_upload     - upload session active
//                ioctl_index      - session index
//                ioctl_rd         - one-cycle byte read request
//                ioctl_addr       - requested byte address
//                ioctl_din        - returned byte
//                ioctl_wait       - stall back to the HPS
//                ioctl_upload_req - one-cycle "please save me" pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface nvram_upload_ctrl_if;

    logic        ioctl_upload;
    logic [15:0] ioctl_index;
    logic        ioctl_rd;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait,
        input  ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait,
        output ioctl_upload_req
    );

endinterface : nvram_upload_ctrl_if
`default_nettype wire

// File: rtl/nvram_quiet_timer.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_quiet_timer
//  Description : Counts cycles since the last core write, saturating at
//                QUIET. expired is high while the count sits at QUIET.
//  Ports       : clk     - clock
//                rst     - asynchronous active-high reset
//                clr     - restart the quiet interval (core write)
//                expired - count has reached QUIET
//  Revision    : 1.0 - initial release
// ============================================================================
module nvram_quiet_timer #(
    parameter int QUIET = 720000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    output logic      expired
);

    localparam int                c_CW    = (QUIET < 2) ? 1 : $clog2(QUIET + 1);
    localparam logic [c_CW-1:0]   c_QUIET = c_CW'(QUIET);
    localparam logic [c_CW-1:0]   c_ONE   = c_CW'(1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_cnt != c_QUIET) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign expired = (r_cnt == c_QUIET);

endmodule : nvram_quiet_timer
`default_nettype wire

// File: rtl/nvram_upload_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_upload_ctrl
//  Description : Save-RAM front end. Passes core byte writes straight to the
//                save RAM, serves HPS ioctl upload reads out of the same RAM
//                (core writes win any collision), tracks whether the RAM
//                holds unsaved data and asks the HPS for an upload once the
//                core has been quiet for QUIET cycles.
//  Ports       : i_EMU_MCLK    - clock
//                i_EMU_INITRST - reset, async assert / sync release
//                i_CORE_WR/ADDR/DATA - core write port
//                ioctl         - HPS upload bus (slave side)
//                o_RAM_WR/RD/ADDR/DATA, i_RAM_Q - save RAM port
//                o_DIRTY       - unsaved data present
//  Revision    : 1.0 - initial release
// ============================================================================
module nvram_upload_ctrl
    import bubsys_pkg::*;
#(
    parameter int          AW     = 13,
    parameter int          SIZE   = 8192,
    parameter int          RD_LAT = 2,
    parameter int          QUIET  = 720000,
    parameter logic [15:0] INDEX  = c_NVRAM_INDEX
) (
    input  wire logic          i_EMU_MCLK,
    input  wire logic          i_EMU_INITRST,
    input  wire logic          i_CORE_WR,
    input  wire logic [AW-1:0] i_CORE_ADDR,
    input  wire logic [7:0]    i_CORE_DATA,
    nvram_upload_ctrl_if.slave ioctl,
    output logic               o_RAM_WR,
    output logic               o_RAM_RD,
    output logic [AW-1:0]      o_RAM_ADDR,
    output logic [7:0]         o_RAM_DATA,
    input  wire logic [7:0]    i_RAM_Q,
    output logic               o_DIRTY
);

    localparam logic [26:0] c_SIZE     = 27'(SIZE);
    localparam logic [1:0]  c_LAT_LAST = 2'(RD_LAT - 1);

    // ------------------------------------------------------------------
    // Reset: asserts immediately, releases two clocks after the input
    // drops so every flop leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Session decode
    // ------------------------------------------------------------------
    logic w_sess;
    assign w_sess = ioctl.ioctl_upload && (ioctl.ioctl_index == INDEX);

    // ------------------------------------------------------------------
    // Upload read FSM
    // ------------------------------------------------------------------
    nvram_state_t r_state;
    logic [26:0]  r_addr;
    logic [1:0]   r_lat_cnt;
    logic         r_wait;
    logic [7:0]   r_din;
    logic         w_oob;

    assign w_oob = (r_addr >= c_SIZE);

    always_ff @(posedge i_EMU_MCLK or posedge w_rst) begin
        if (w_rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_lat_cnt <= '0;
            r_wait    <= 1'b0;
            r_din     <= c_BLANK_BYTE;
        end else if ((r_state != IDLE) && !w_sess) begin
            // Session dropped mid-read: release the HPS, keep the old byte.
            r_state <= IDLE;
            r_wait  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (ioctl.ioctl_rd && w_sess) begin
                        r_addr  <= ioctl.ioctl_addr;
                        r_wait  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_oob) begin
                        r_din   <= c_BLANK_BYTE;
                        r_state <= HOLD;
                    end else if (!i_CORE_WR) begin
                        // RAM port is ours this cycle; otherwise retry next.
                        r_lat_cnt <= '0;
                        r_state   <= LAT;
                    end
                end
                LAT: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_din   <= i_RAM_Q;
                        r_state <= HOLD;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                HOLD: begin
                    r_wait  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_wait  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // RAM port: the core write path is combinational and always wins.
    assign o_RAM_WR   = i_CORE_WR;
    assign o_RAM_DATA = i_CORE_DATA;
    assign o_RAM_RD   = (r_state == ISSUE) && w_sess && !w_oob && !i_CORE_WR;
    assign o_RAM_ADDR = i_CORE_WR ? i_CORE_ADDR : r_addr[AW-1:0];

    assign ioctl.ioctl_din  = r_din;
    assign ioctl.ioctl_wait = r_wait;

    // ------------------------------------------------------------------
    // Dirty tracking and upload request
    // ------------------------------------------------------------------
    logic w_expired;

    nvram_quiet_timer #(
        .QUIET (QUIET)
    ) u_quiet (
        .clk     (i_EMU_MCLK),
        .rst     (w_rst),
        .clr     (i_CORE_WR),
        .expired (w_expired)
    );

    logic r_sess_d;
    logic r_pend;
    logic r_dirty;
    logic r_req_sent;
    logic r_req;

    always_ff @(posedge i_EMU_MCLK or posedge w_rst) begin
        if (w_rst) begin
            r_sess_d   <= 1'b0;
            r_pend     <= 1'b0;
            r_dirty    <= 1'b0;
            r_req_sent <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            r_sess_d <= w_sess;
            r_req    <= 1'b0;

            // The upload just taken is a snapshot from session start;
            // only writes made during it keep the RAM dirty afterwards.
            if (w_sess && !r_sess_d) begin
                r_pend <= 1'b0;
            end
            if (!w_sess && r_sess_d) begin
                r_dirty <= r_pend;
            end

            if (i_CORE_WR) begin
                r_dirty    <= 1'b1;
                r_req_sent <= 1'b0;
                if (w_sess) begin
                    r_pend <= 1'b1;
                end
            end else if (r_dirty && !r_req_sent && !w_sess && w_expired) begin
                r_req      <= 1'b1;
                r_req_sent <= 1'b1;
            end
        end
    end

    assign o_DIRTY                = r_dirty;
    assign ioctl.ioctl_upload_req = r_req;

endmodule : nvram_upload_ctrl
`default_nettype wire
